// File: rtl/instr_decode.sv
// AAP decode stage: rebuilds 16/32-bit instructions from fetch words and issues them registered.
// Optional DECODE_ILLEGAL_TRAP_EN flags unsupported 48/64-bit second words via dec_illegal.
module instr_decode #(
    parameter int PC_W = 20
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     fetch_word,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic            flush,
    input  logic            stall,
    output logic            dec_valid,
    output logic            dec_is32,
    output logic [1:0]      dec_class,
    output logic [7:0]      dec_opcode,
    output logic [5:0]      dec_rd,
    output logic [5:0]      dec_ra,
    output logic [5:0]      dec_rb,
    output logic [11:0]     dec_imm,
    output logic [PC_W-1:0] dec_pc,
    output logic            dec_illegal
);

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [14:0]       hold_word_r;
    logic [PC_W-1:0]   hold_pc_r;
    logic              accept_s;
    logic              issue_s;
    logic              hold_load_s;
    logic              is32_nxt_s;
    logic [1:0]        class_nxt_s;
    logic [7:0]        opcode_nxt_s;
    logic [5:0]        rd_nxt_s;
    logic [5:0]        ra_nxt_s;
    logic [5:0]        rb_nxt_s;
    logic [11:0]       imm_nxt_s;
    logic [PC_W-1:0]   pc_nxt_s;
    logic              illegal_nxt_s;

    // Back-pressure: refuse words only while an issued instruction is being held.
    assign fetch_ready = !(dec_valid && stall);
    assign accept_s    = fetch_valid && fetch_ready;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FIRST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; flush abandons any partial instruction.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_FIRST;
        end else if (accept_s) begin
            case (state_r)
                ST_FIRST:  state_nxt_s = fetch_word[15] ? ST_SECOND : ST_FIRST;
                ST_SECOND: state_nxt_s = ST_FIRST;
                default:   state_nxt_s = ST_FIRST;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM outputs: issue strobe, hold-register load and the next decoded fields.
    always_comb begin
        issue_s       = 1'b0;
        hold_load_s   = 1'b0;
        is32_nxt_s    = 1'b0;
        class_nxt_s   = fetch_word[14:13];
        opcode_nxt_s  = {4'b0000, fetch_word[12:9]};
        rd_nxt_s      = {3'b000, fetch_word[8:6]};
        ra_nxt_s      = {3'b000, fetch_word[5:3]};
        rb_nxt_s      = {3'b000, fetch_word[2:0]};
        imm_nxt_s     = {6'b000000, fetch_word[5:3], fetch_word[2:0]};
        pc_nxt_s      = fetch_pc;
        illegal_nxt_s = 1'b0;
        case (state_r)
            ST_FIRST: begin
                if (accept_s && !flush) begin
                    issue_s     = !fetch_word[15];
                    hold_load_s = fetch_word[15];
                end else begin
                    issue_s     = 1'b0;
                    hold_load_s = 1'b0;
                end
            end
            ST_SECOND: begin
                issue_s      = accept_s && !flush;
                is32_nxt_s   = 1'b1;
                class_nxt_s  = hold_word_r[14:13];
                opcode_nxt_s = {fetch_word[12:9], hold_word_r[12:9]};
                rd_nxt_s     = {fetch_word[8:6], hold_word_r[8:6]};
                ra_nxt_s     = {fetch_word[5:3], hold_word_r[5:3]};
                rb_nxt_s     = {fetch_word[2:0], hold_word_r[2:0]};
                imm_nxt_s    = {fetch_word[5:3], fetch_word[2:0], hold_word_r[5:3], hold_word_r[2:0]};
                pc_nxt_s     = hold_pc_r;
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal_nxt_s = fetch_word[15];
`else
                illegal_nxt_s = 1'b0;
`endif
            end
            default: begin
                issue_s     = 1'b0;
                hold_load_s = 1'b0;
            end
        endcase
    end

    // Hold register for the first half of a 32-bit instruction.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            hold_word_r <= 15'h0000;
            hold_pc_r   <= {PC_W{1'b0}};
        end else if (hold_load_s) begin
            hold_word_r <= fetch_word[14:0];
            hold_pc_r   <= fetch_pc;
        end
    end

    // Issued-instruction register; a stall freezes it, otherwise valid drops without an issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            dec_valid   <= 1'b0;
            dec_is32    <= 1'b0;
            dec_class   <= 2'b00;
            dec_opcode  <= 8'h00;
            dec_rd      <= 6'h00;
            dec_ra      <= 6'h00;
            dec_rb      <= 6'h00;
            dec_imm     <= 12'h000;
            dec_pc      <= {PC_W{1'b0}};
            dec_illegal <= 1'b0;
        end else if (flush) begin
            dec_valid   <= 1'b0;
            dec_illegal <= 1'b0;
        end else if (stall && dec_valid) begin
            dec_valid   <= dec_valid;
        end else if (issue_s) begin
            dec_valid   <= 1'b1;
            dec_is32    <= is32_nxt_s;
            dec_class   <= class_nxt_s;
            dec_opcode  <= opcode_nxt_s;
            dec_rd      <= rd_nxt_s;
            dec_ra      <= ra_nxt_s;
            dec_rb      <= rb_nxt_s;
            dec_imm     <= imm_nxt_s;
            dec_pc      <= pc_nxt_s;
            dec_illegal <= illegal_nxt_s;
        end else begin
            dec_valid   <= 1'b0;
            dec_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode with hand-computed expected fields.
module tb_instr_decode;

    localparam int PC_W = 20;

    logic            clock;
    logic            reset;
    logic [15:0]     fetch_word;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_valid;
    logic            fetch_ready;
    logic            flush;
    logic            stall;
    logic            dec_valid;
    logic            dec_is32;
    logic [1:0]      dec_class;
    logic [7:0]      dec_opcode;
    logic [5:0]      dec_rd;
    logic [5:0]      dec_ra;
    logic [5:0]      dec_rb;
    logic [11:0]     dec_imm;
    logic [PC_W-1:0] dec_pc;
    logic            dec_illegal;

    int checks_cnt;
    int fail_cnt;

    instr_decode #(.PC_W(PC_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_word  (fetch_word),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .stall       (stall),
        .dec_valid   (dec_valid),
        .dec_is32    (dec_is32),
        .dec_class   (dec_class),
        .dec_opcode  (dec_opcode),
        .dec_rd      (dec_rd),
        .dec_ra      (dec_ra),
        .dec_rb      (dec_rb),
        .dec_imm     (dec_imm),
        .dec_pc      (dec_pc),
        .dec_illegal (dec_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] w, input logic [PC_W-1:0] pc);
        fetch_word  = w;
        fetch_pc    = pc;
        fetch_valid = 1'b1;
    endtask

    task automatic check_insn(input string tag, input logic is32, input logic [1:0] cls,
                              input logic [7:0] opc, input logic [5:0] rd, input logic [5:0] ra,
                              input logic [5:0] rb, input logic [11:0] imm, input logic [PC_W-1:0] pc);
        check({tag, ".valid"},  {31'd0, dec_valid},  32'd1);
        check({tag, ".is32"},   {31'd0, dec_is32},   {31'd0, is32});
        check({tag, ".class"},  {30'd0, dec_class},  {30'd0, cls});
        check({tag, ".opcode"}, {24'd0, dec_opcode}, {24'd0, opc});
        check({tag, ".rd"},     {26'd0, dec_rd},     {26'd0, rd});
        check({tag, ".ra"},     {26'd0, dec_ra},     {26'd0, ra});
        check({tag, ".rb"},     {26'd0, dec_rb},     {26'd0, rb});
        check({tag, ".imm"},    {20'd0, dec_imm},    {20'd0, imm});
        check({tag, ".pc"},     {12'd0, dec_pc},     {12'd0, pc});
    endtask

    initial begin
        logic exp_illegal;
        checks_cnt  = 0;
        fail_cnt    = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        stall       = 1'b0;
        fetch_valid = 1'b0;
        fetch_word  = 16'h0000;
        fetch_pc    = 20'h00000;
        step();
        step();
        reset = 1'b0;
        check("rst.valid",   {31'd0, dec_valid},   32'd0);
        check("rst.ready",   {31'd0, fetch_ready}, 32'd1);
        check("rst.opcode",  {24'd0, dec_opcode},  32'd0);
        check("rst.pc",      {12'd0, dec_pc},      32'd0);
        check("rst.illegal", {31'd0, dec_illegal}, 32'd0);

        // 16-bit issue, one-cycle latency.
        drive(16'h0A53, 20'h00010);
        step();
        fetch_valid = 1'b0;
        check_insn("w16", 1'b0, 2'd0, 8'h05, 6'd1, 6'd2, 6'd3, 12'h013, 20'h00010);
        step();
        check("w16.drop", {31'd0, dec_valid}, 32'd0);

        // 32-bit pair: nothing after the first half.
        drive(16'h8A53, 20'h00020);
        step();
        check("w32.first", {31'd0, dec_valid}, 32'd0);
        drive(16'h1E91, 20'h00021);
        step();
        fetch_valid = 1'b0;
        check_insn("w32", 1'b1, 2'd0, 8'hF5, 6'h11, 6'h12, 6'h0B, 12'h453, 20'h00020);

        // Stall holds an issued instruction and blocks fetch.
        drive(16'h2C8E, 20'h00030);
        step();
        check_insn("w16b", 1'b0, 2'd1, 8'h06, 6'd2, 6'd1, 6'd6, 12'h00E, 20'h00030);
        stall = 1'b1;
        drive(16'h0A53, 20'h00040);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.ready",  {31'd0, fetch_ready}, 32'd0);
            check("stall.valid",  {31'd0, dec_valid},   32'd1);
            check("stall.pc",     {12'd0, dec_pc},      32'h00030);
            check("stall.opcode", {24'd0, dec_opcode},  32'h06);
            check("stall.imm",    {20'd0, dec_imm},     32'h00E);
        end
        stall = 1'b0;
        step();
        fetch_valid = 1'b0;
        check_insn("unstall", 1'b0, 2'd0, 8'h05, 6'd1, 6'd2, 6'd3, 12'h013, 20'h00040);

        // Flush drops a pending first half; the flush-cycle word is ignored.
        drive(16'h8A53, 20'h00050);
        step();
        flush = 1'b1;
        drive(16'h0A53, 20'h00051);
        step();
        flush = 1'b0;
        check("flush.valid", {31'd0, dec_valid}, 32'd0);
        drive(16'h0A53, 20'h00060);
        step();
        fetch_valid = 1'b0;
        check_insn("postflush", 1'b0, 2'd0, 8'h05, 6'd1, 6'd2, 6'd3, 12'h013, 20'h00060);

        // Two idle cycles between halves.
        drive(16'h8A53, 20'h00070);
        step();
        fetch_valid = 1'b0;
        step();
        check("gap.valid1", {31'd0, dec_valid}, 32'd0);
        step();
        check("gap.valid2", {31'd0, dec_valid}, 32'd0);
        drive(16'h1E91, 20'h00072);
        step();
        fetch_valid = 1'b0;
        check_insn("gap", 1'b1, 2'd0, 8'hF5, 6'h11, 6'h12, 6'h0B, 12'h453, 20'h00070);

        // Stall with nothing issued has no effect.
        step();
        stall = 1'b1;
        drive(16'h0A53, 20'h00090);
        step();
        fetch_valid = 1'b0;
        stall = 1'b0;
        check_insn("idlestall", 1'b0, 2'd0, 8'h05, 6'd1, 6'd2, 6'd3, 12'h013, 20'h00090);

        // Second word with the long flag set.
`ifdef DECODE_ILLEGAL_TRAP_EN
        exp_illegal = 1'b1;
`else
        exp_illegal = 1'b0;
`endif
        drive(16'h8000, 20'h000A0);
        step();
        drive(16'h8000, 20'h000A1);
        step();
        fetch_valid = 1'b0;
        check_insn("long", 1'b1, 2'd0, 8'h00, 6'd0, 6'd0, 6'd0, 12'h000, 20'h000A0);
        check("long.illegal", {31'd0, dec_illegal}, {31'd0, exp_illegal});
        step();
        check("long.clear", {31'd0, dec_illegal}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
